// File: rtl/io_uart_in.sv
// 8N1 serial receiver on the dma_io bus: synchroniser, bit-timing FSM, byte FIFO,
// data/status registers in the read-data daisy chain and a level interrupt.
module io_uart_in #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_AW      = 4,
  parameter logic [13:0] DATA_ADR     = 14'h3E10,
  parameter logic [13:0] STAT_ADR     = 14'h3E11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_in,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        rx_int
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // [0],[1] form the synchroniser (rx_s); [2] is the edge-detect delay (rx_q)
  logic [2:0] rx_pipe_reg;
  logic       rx_s;
  logic       rx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_pipe_reg <= '1;
    else     rx_pipe_reg <= {rx_pipe_reg[1:0], uart_rx_in};
  end

  assign rx_s = rx_pipe_reg[1];
  assign rx_q = rx_pipe_reg[2];

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (rx_q && !rx_s) state_reg <= ST_START;
        end
        ST_START: begin
          if (cnt_reg == CNT_MID) begin
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            state_reg   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx_reg == 3'd7) state_reg <= ST_STOP;
            else                     bit_idx_reg <= bit_idx_reg + 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          if (cnt_reg == CNT_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  logic stop_done;
  logic rx_push;
  logic rx_ferr;

  assign stop_done = (state_reg == ST_STOP) && (cnt_reg == CNT_LAST);
  assign rx_push   = stop_done && rx_s;
  assign rx_ferr   = stop_done && !rx_s;

  // FIFO bookkeeping
  logic [FIFO_AW-1:0] wr_ptr_reg;
  logic [FIFO_AW-1:0] rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg;
  logic               fifo_full;
  logic               fifo_nonempty;
  logic               rd_data_hit;
  logic               rd_stat_hit;
  logic               stat_wr;
  logic               fifo_wr;
  logic               fifo_pop;
  logic               ovr_set;

  assign fifo_full     = (count_reg == COUNT_FULL);
  assign fifo_nonempty = (count_reg != '0);
  assign rd_data_hit   = dma_io_radr_en && (dma_io_radr == DATA_ADR);
  assign rd_stat_hit   = dma_io_radr_en && (dma_io_radr == STAT_ADR);
  assign stat_wr       = dma_io_we && (dma_io_wadr == STAT_ADR);
  assign fifo_wr       = rx_push && !fifo_full;
  assign ovr_set       = rx_push && fifo_full;
  assign fifo_pop      = rd_data_hit && fifo_nonempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_wr)  wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_wr, fifo_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage is left unreset so it maps onto block RAM with a registered read port
  logic [7:0] fifo_mem [DEPTH];
  logic [7:0] mem_q_reg;

  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_reg] <= shift_reg;
    mem_q_reg <= fifo_mem[rd_ptr_reg];
  end

  logic overrun_reg;
  logic frame_err_reg;
  logic int_en_reg;

  // A set event in the same cycle as a write-1-clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      int_en_reg    <= 1'b0;
    end else begin
      if (stat_wr) int_en_reg <= dma_io_wdata[4];
      if (ovr_set)                        overrun_reg <= 1'b1;
      else if (stat_wr && dma_io_wdata[2]) overrun_reg <= 1'b0;
      if (rx_ferr)                        frame_err_reg <= 1'b1;
      else if (stat_wr && dma_io_wdata[3]) frame_err_reg <= 1'b0;
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^{dma_io_wdata[31:5], dma_io_wdata[1:0]};

  logic [31:0] status_word;

  always_comb begin
    status_word                  = '0;
    status_word[0]               = fifo_nonempty;
    status_word[1]               = fifo_full;
    status_word[2]               = overrun_reg;
    status_word[3]               = frame_err_reg;
    status_word[4]               = int_en_reg;
    status_word[8 +: FIFO_AW+1]  = count_reg;
  end

  logic        sel_reg;
  logic        rd_is_data_reg;
  logic        rd_valid_reg;
  logic [31:0] stat_q_reg;
  logic [31:0] own_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_reg        <= 1'b0;
      rd_is_data_reg <= 1'b0;
      rd_valid_reg   <= 1'b0;
      stat_q_reg     <= '0;
    end else begin
      sel_reg        <= rd_data_hit || rd_stat_hit;
      rd_is_data_reg <= rd_data_hit;
      rd_valid_reg   <= fifo_nonempty;
      stat_q_reg     <= rd_stat_hit ? status_word : '0;
    end
  end

  // Data word is assembled after the RAM's registered read port
  assign own_rdata = rd_is_data_reg ? (rd_valid_reg ? {23'd0, 1'b1, mem_q_reg} : 32'd0)
                                    : stat_q_reg;

  assign dma_io_rdata = sel_reg ? own_rdata : dma_io_rdata_in;
  assign rx_int       = int_en_reg && fifo_nonempty;

endmodule

// File: tb/tb_io_uart_in.sv
// Directed-plus-random bench for io_uart_in: drives 8N1 frames on the rx pin and
// compares register reads and rx_int against a queue-based receiver model.
module tb_io_uart_in;

  localparam int          CPB      = 8;
  localparam int          AW       = 4;
  localparam int          DEPTH    = 16;
  localparam logic [13:0] DATA_ADR = 14'h3E10;
  localparam logic [13:0] STAT_ADR = 14'h3E11;

  logic        clk;
  logic        rst;
  logic        uart_rx_in;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata_in;
  logic [31:0] dma_io_rdata;
  logic        rx_int;

  io_uart_in #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW     (AW),
    .DATA_ADR    (DATA_ADR),
    .STAT_ADR    (STAT_ADR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_rx_in     (uart_rx_in),
    .dma_io_we      (dma_io_we),
    .dma_io_wadr    (dma_io_wadr),
    .dma_io_wdata   (dma_io_wdata),
    .dma_io_radr    (dma_io_radr),
    .dma_io_radr_en (dma_io_radr_en),
    .dma_io_rdata_in(dma_io_rdata_in),
    .dma_io_rdata   (dma_io_rdata),
    .rx_int         (rx_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Receiver model: bytes waiting to be read plus the sticky/control bits
  logic [7:0] ref_q[$];
  logic       ref_ovr;
  logic       ref_ferr;
  logic       ref_ie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (ref_q.size() == DEPTH) ref_ovr = 1'b1;
    else                       ref_q.push_back(b);
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (ref_q.size() != 0);
    s[1]     = (ref_q.size() == DEPTH);
    s[2]     = ref_ovr;
    s[3]     = ref_ferr;
    s[4]     = ref_ie;
    s[12:8]  = 5'(ref_q.size());
    return s;
  endfunction

  function automatic logic [31:0] exp_data_pop();
    if (ref_q.size() == 0) return 32'd0;
    return {23'd0, 1'b1, ref_q.pop_front()};
  endfunction

  // Caller is at a negedge; returns at a negedge just after the stop bit
  task automatic send_frame(input logic [7:0] b, input logic stop);
    uart_rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx_in = stop;
    repeat (CPB) @(negedge clk);
    uart_rx_in = 1'b1;
  endtask

  task automatic read_reg(input logic [13:0] adr, output logic [31:0] data);
    @(negedge clk);
    dma_io_radr    = adr;
    dma_io_radr_en = 1'b1;
    @(negedge clk);
    dma_io_radr_en = 1'b0;
    data           = dma_io_rdata;
  endtask

  task automatic write_reg(input logic [13:0] adr, input logic [31:0] d);
    @(negedge clk);
    dma_io_we    = 1'b1;
    dma_io_wadr  = adr;
    dma_io_wdata = d;
    @(negedge clk);
    dma_io_we    = 1'b0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] r;
    read_reg(STAT_ADR, r);
    check(tag, r, exp_status());
  endtask

  task automatic read_data(input string tag);
    logic [31:0] r;
    logic [31:0] e;
    read_reg(DATA_ADR, r);
    e = exp_data_pop();
    check(tag, r, e);
  endtask

  task automatic check_int(input string tag);
    check(tag, {31'd0, rx_int}, {31'd0, ref_ie && (ref_q.size() != 0)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  b;
    logic [7:0]  b2;
    logic [31:0] r;
    logic [31:0] e;

    rst             = 1'b1;
    uart_rx_in      = 1'b1;
    dma_io_we       = 1'b0;
    dma_io_wadr     = '0;
    dma_io_wdata    = '0;
    dma_io_radr     = '0;
    dma_io_radr_en  = 1'b0;
    dma_io_rdata_in = $urandom;
    ref_ovr = 1'b0; ref_ferr = 1'b0; ref_ie = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_chain", dma_io_rdata, dma_io_rdata_in);
    check("reset_int", {31'd0, rx_int}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_status("reset_status");

    // Single known frame, then a few random ones
    send_frame(8'h55, 1'b1); model_rx(8'h55);
    check_status("t1_status_full1");
    read_data("t1_data");
    check_status("t1_status_empty");
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1); model_rx(b);
      read_data("rand_data");
    end

    // Overfill: 17 frames with no reads
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b1); model_rx(8'(i));
    end
    check_status("t2_full_overrun");
    for (int i = 0; i < 17; i++) read_data("t2_drain");
    write_reg(STAT_ADR, 32'h4); ref_ovr = 1'b0;
    check_status("t2_ovr_clear");

    // Bad stop bit, then write-1-clear
    send_frame(8'hA3, 1'b0); ref_ferr = 1'b1;
    repeat (2) @(negedge clk);
    check_status("t3_frame_err");
    write_reg(STAT_ADR, 32'h8); ref_ferr = 1'b0;
    check_status("t3_ferr_clear");

    // Two-clock glitch must not start a frame
    @(negedge clk); uart_rx_in = 1'b0;
    repeat (2) @(negedge clk); uart_rx_in = 1'b1;
    repeat (20) @(negedge clk);
    check_status("t4_glitch");
    send_frame(8'h3C, 1'b1); model_rx(8'h3C);
    read_data("t4_after_glitch");

    // Data read lands on the same edge as the next push
    b = 8'($urandom); b2 = 8'($urandom);
    send_frame(b, 1'b1); model_rx(b);
    @(negedge clk);
    fork
      send_frame(b2, 1'b1);
      begin
        repeat (78) @(posedge clk);
        @(negedge clk);
        e = exp_data_pop();
        dma_io_radr    = DATA_ADR;
        dma_io_radr_en = 1'b1;
        @(negedge clk);
        check("t5_coincide_data", dma_io_rdata, e);
        dma_io_radr_en = 1'b0;
      end
    join
    model_rx(b2);
    check_status("t5_count1");
    read_data("t5_new_byte");

    // Foreign address passes the chain through
    dma_io_rdata_in = 32'hDEADBEEF;
    read_reg(14'h0123, r);
    check("t6_chain", r, 32'hDEADBEEF);
    write_reg(DATA_ADR, 32'h10);
    check_status("t6_data_write_ignored");
    write_reg(STAT_ADR, 32'h10); ref_ie = 1'b1;
    check_int("t6_int_empty");
    b = 8'($urandom);
    send_frame(b, 1'b1); model_rx(b);
    check_int("t6_int_set");
    check_status("t6_status_ie");
    read_data("t6_pop");
    check_int("t6_int_clear");

    // Random traffic with occasional reads, then drain
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1); model_rx(b);
      if ($urandom_range(0, 1) == 1) read_data("rand_mix");
      check_int("rand_int");
    end
    while (ref_q.size() != 0) read_data("rand_drain");
    read_data("empty_read");

    // Reset in the middle of a frame
    b = 8'($urandom);
    send_frame(b, 1'b1); model_rx(b);
    check_int("pre_reset_int");
    uart_rx_in = 1'b0;
    repeat (CPB) @(negedge clk); uart_rx_in = 1'b1;
    repeat (CPB) @(negedge clk); uart_rx_in = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1; uart_rx_in = 1'b1; dma_io_rdata_in = $urandom;
    repeat (2) @(negedge clk);
    check("midrst_int", {31'd0, rx_int}, 32'd0);
    check("midrst_chain", dma_io_rdata, dma_io_rdata_in);
    rst = 1'b0;
    ref_q.delete(); ref_ovr = 1'b0; ref_ferr = 1'b0; ref_ie = 1'b0;
    repeat (120) @(negedge clk);
    check_status("midrst_status");
    b = 8'($urandom);
    send_frame(b, 1'b1); model_rx(b);
    read_data("midrst_recover");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
